// File: rtl/midi_route_sched.sv
`default_nettype none
// ============================================================================
// midi_route_sched : round-robin MIDI byte router with per-source message lock
// Revision 1.0
// ============================================================================
module midi_route_sched #(
   parameter int PORTS        = 8,
   parameter int LOCK_TIMEOUT = 12_000_000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORTS-1:0]         rx_empty,
   output logic [PORTS-1:0]         rx_rden,
   input  logic [PORTS*8-1:0]       rxdata,
   input  logic [PORTS-1:0]         tx_busy,
   output logic [PORTS-1:0]         txdv,
   output logic [PORTS*8-1:0]       txdata,
   output logic [PORTS*4-1:0]       txcurport,
   input  logic [PORTS*PORTS-1:0]   route_map
);

   localparam int SW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [SW-1:0] c_last_port = SW'(PORTS - 1);
   localparam logic [TW-1:0] c_to_max    = TW'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ARB    = 3'd0,
      READ   = 3'd1,
      LATCH  = 3'd2,
      SEND   = 3'd3,
      UPDATE = 3'd4
   } state_t;

   state_t            r_state;
   logic [SW-1:0]     r_src;
   logic [SW-1:0]     r_last;
   logic [SW-1:0]     r_d;
   logic [7:0]        r_byte;
   logic [PORTS-1:0]  r_mask;
   logic              r_locked;
   logic [SW-1:0]     r_lock_src;
   logic [TW-1:0]     r_to_cnt;
   logic [1:0]        r_need  [PORTS];
   logic [1:0]        r_run   [PORTS];
   logic              r_sysex [PORTS];

   logic              w_found;
   logic [SW-1:0]     w_pick;
   logic [SW-1:0]     w_cand;
   logic [1:0]        w_need_n;
   logic [1:0]        w_run_n;
   logic              w_sysex_n;
   logic              w_lock_set;
   logic              w_lock_clr;

   // While locked only the lock holder may be granted; otherwise rotate from last_grant+1.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      if (r_locked) begin
         w_found = !rx_empty[r_lock_src];
         w_pick  = r_lock_src;
      end else begin
         for (int i = 1; i <= PORTS; i++) begin
            w_cand = SW'((int'(r_last) + i) % PORTS);
            if (!w_found && !rx_empty[w_cand]) begin
               w_found = 1'b1;
               w_pick  = w_cand;
            end
         end
      end
   end

   // Message tracker next state for the byte just forwarded from r_src.
   always_comb begin
      w_need_n   = r_need[r_src];
      w_run_n    = r_run[r_src];
      w_sysex_n  = r_sysex[r_src];
      w_lock_set = 1'b0;
      w_lock_clr = 1'b0;
      if (r_byte[7]) begin
         if (r_byte[7:4] != 4'hF) begin
            if (r_byte[7:5] == 3'b110) begin
               w_need_n = 2'd1;
               w_run_n  = 2'd1;
            end else begin
               w_need_n = 2'd2;
               w_run_n  = 2'd2;
            end
            w_lock_set = 1'b1;
         end else begin
            case (r_byte[3:0])
               4'h0: begin
                  w_sysex_n  = 1'b1;
                  w_lock_set = 1'b1;
               end
               4'h1, 4'h3: begin
                  w_need_n   = 2'd1;
                  w_run_n    = 2'd0;
                  w_lock_set = 1'b1;
               end
               4'h2: begin
                  w_need_n   = 2'd2;
                  w_run_n    = 2'd0;
                  w_lock_set = 1'b1;
               end
               4'h4, 4'h5, 4'h6: begin
                  w_need_n   = 2'd0;
                  w_run_n    = 2'd0;
                  w_lock_clr = 1'b1;
               end
               4'h7: begin
                  w_sysex_n  = 1'b0;
                  w_need_n   = 2'd0;
                  w_lock_clr = 1'b1;
               end
               default: ; // realtime passes through untouched
            endcase
         end
      end else if (!r_sysex[r_src]) begin
         if (r_need[r_src] != 2'd0) begin
            w_need_n = r_need[r_src] - 2'd1;
            if (r_need[r_src] == 2'd1)
               w_lock_clr = 1'b1;
         end else if (r_run[r_src] != 2'd0) begin
            w_need_n = r_run[r_src] - 2'd1;
            if (r_run[r_src] == 2'd2)
               w_lock_set = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ARB;
         r_src      <= '0;
         r_last     <= c_last_port;
         r_d        <= '0;
         r_byte     <= '0;
         r_mask     <= '0;
         r_locked   <= 1'b0;
         r_lock_src <= '0;
         r_to_cnt   <= '0;
         rx_rden    <= '0;
         txdv       <= '0;
         txdata     <= '0;
         txcurport  <= '0;
         for (int i = 0; i < PORTS; i++) begin
            r_need[i]  <= '0;
            r_run[i]   <= '0;
            r_sysex[i] <= 1'b0;
         end
      end else begin
         rx_rden <= '0;
         txdv    <= '0;
         case (r_state)
            ARB: begin
               if (w_found) begin
                  r_src           <= w_pick;
                  rx_rden[w_pick] <= 1'b1;
                  r_to_cnt        <= '0;
                  r_state         <= READ;
               end else if (r_locked && rx_empty[r_lock_src]) begin
                  // An abandoned message must not starve the other sources forever.
                  if (r_to_cnt >= c_to_max) begin
                     r_locked              <= 1'b0;
                     r_need[r_lock_src]    <= '0;
                     r_sysex[r_lock_src]   <= 1'b0;
                     r_to_cnt              <= '0;
                  end else begin
                     r_to_cnt <= r_to_cnt + 1'b1;
                  end
               end
            end
            READ: begin
               r_state <= LATCH;
            end
            LATCH: begin
               r_byte  <= rxdata[r_src*8 +: 8];
               r_mask  <= route_map[r_src*PORTS +: PORTS];
               r_d     <= '0;
               r_state <= SEND;
            end
            SEND: begin
               if (!(r_mask[r_d] && tx_busy[r_d])) begin
                  if (r_mask[r_d]) begin
                     txdv[r_d]               <= 1'b1;
                     txdata[r_d*8 +: 8]      <= r_byte;
                     txcurport[r_d*4 +: 4]   <= 4'(r_src);
                  end
                  if (r_d == c_last_port)
                     r_state <= UPDATE;
                  else
                     r_d <= r_d + 1'b1;
               end
            end
            UPDATE: begin
               r_need[r_src]  <= w_need_n;
               r_run[r_src]   <= w_run_n;
               r_sysex[r_src] <= w_sysex_n;
               if (w_lock_set) begin
                  r_locked   <= 1'b1;
                  r_lock_src <= r_src;
               end else if (w_lock_clr) begin
                  r_locked   <= 1'b0;
               end
               r_last  <= r_src;
               r_state <= ARB;
            end
            default: r_state <= ARB;
         endcase
      end
   end

endmodule
`default_nettype wire
